// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the sp_ram_ctrl scratch memory.
// Optional feature macro: SP_RAM_PARITY_EN (per-byte even parity).
package sp_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sp_ram_state_t;

    // Legal read-latency settings
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    // Even parity bit for one byte: total number of ones including the bit is even
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sp_ram_ctrl_if.sv
// Request/response bus of sp_ram_ctrl.
// Optional feature macro: SP_RAM_PARITY_EN adds the inj_perr request signal.
interface sp_ram_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
`ifdef SP_RAM_PARITY_EN
    logic                  inj_perr;
`endif
    logic                  ready;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  err;

    modport master (
`ifdef SP_RAM_PARITY_EN
        output inj_perr,
`endif
        output req, we, addr, wdata, wstrb,
        input  ready, rvalid, rdata, err
    );

    modport slave (
`ifdef SP_RAM_PARITY_EN
        input  inj_perr,
`endif
        input  req, we, addr, wdata, wstrb,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/sp_ram_array.sv
// Plain single-port storage: per-lane write enables and a registered read.
// Has no reset so it can be mapped onto block RAM.
module sp_ram_array #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [LANES-1:0]               be,
    input  logic [ADDR_W-1:0]              addr,
    input  logic [LANES-1:0][LANE_W-1:0]   wdata,
    output logic [LANES-1:0][LANE_W-1:0]   rdata
);

    logic [LANES-1:0][LANE_W-1:0] mem [DEPTH];

    // Lane-masked write and registered read of the addressed word.
    // NOTE: storage and its read register are deliberately not reset; a reset would block RAM inference, and the controller's INIT sweep provides the defined contents.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) mem[addr][i] <= wdata[i];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: single-port scratch RAM with request/ready front end, byte strobes,
// 1- or 2-cycle read pipeline and a clear sweep after reset or clr.
// Optional feature macro: SP_RAM_PARITY_EN (stored even parity per byte, error on read).
module sp_ram_ctrl
    import sp_ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 2**ADDR_W,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    sp_ram_ctrl_if.slave  bus
);

    localparam int NB = DATA_W / 8;
`ifdef SP_RAM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif

    sp_ram_state_t                state_q, state_d;
    logic [ADDR_W-1:0]            cnt_q, cnt_d;
    logic                         accept, oor;
    logic                         arr_en;
    logic [NB-1:0]                arr_be;
    logic [ADDR_W-1:0]            arr_addr;
    logic [NB-1:0][LANE_W-1:0]    wr_lanes, arr_wdata, arr_rdata;
    logic [DATA_W-1:0]            rd_word;
    logic                         perr;
    logic                         s1_rd, s1_oor;
    logic                         s2_rvalid, s2_err;
    logic [DATA_W-1:0]            s2_rdata;

    assign bus.ready = (state_q == RUN);
    assign accept    = bus.req && bus.ready;
    assign oor       = {1'b0, bus.addr} >= (ADDR_W+1)'(DEPTH);

    // FSM state and sweep counter register.
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, sweep counter and array port control.
    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arr_en    = 1'b0;
        arr_be    = '0;
        arr_addr  = bus.addr;
        arr_wdata = wr_lanes;
        case (state_q)
            INIT: begin
                arr_en    = 1'b1;
                arr_be    = '1;
                arr_addr  = cnt_q;
                arr_wdata = '0;
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (accept && !oor) begin
                    arr_en = 1'b1;
                    arr_be = bus.we ? bus.wstrb : '0;
                end
                if (clr) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Split write data into byte lanes, appending parity when enabled.
    always_comb begin
        wr_lanes = '0;
        for (int i = 0; i < NB; i++) begin
`ifdef SP_RAM_PARITY_EN
            wr_lanes[i] = {byte_parity(bus.wdata[8*i +: 8]) ^ ((i == 0) && bus.inj_perr),
                           bus.wdata[8*i +: 8]};
`else
            wr_lanes[i] = bus.wdata[8*i +: 8];
`endif
        end
    end

    // Reassemble the read word from lanes and check stored parity.
    always_comb begin
        rd_word = '0;
        perr    = 1'b0;
        for (int i = 0; i < NB; i++) begin
            rd_word[8*i +: 8] = arr_rdata[i][7:0];
`ifdef SP_RAM_PARITY_EN
            if (arr_rdata[i][8] != byte_parity(arr_rdata[i][7:0])) perr = 1'b1;
`endif
        end
    end

    sp_ram_array #(
        .LANES  (NB),
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk    (clk),
        .en     (arr_en),
        .be     (arr_be),
        .addr   (arr_addr),
        .wdata  (arr_wdata),
        .rdata  (arr_rdata)
    );

    // Stage 1: remember accepted reads and out-of-range accesses alongside the array read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rd  <= 1'b0;
            s1_oor <= 1'b0;
        end else begin
            s1_rd  <= accept && !bus.we;
            s1_oor <= accept && oor;
        end
    end

    // Stage 2: response register; rdata only updates on a read and is forced to zero out of range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_rvalid <= 1'b0;
            s2_err    <= 1'b0;
            s2_rdata  <= '0;
        end else begin
            s2_rvalid <= s1_rd;
            s2_err    <= s1_oor || (s1_rd && perr);
            if (s1_rd) s2_rdata <= s1_oor ? '0 : rd_word;
        end
    end

    generate
        if (READ_LAT > READ_LAT_MIN) begin : g_lat2
            logic              o_rvalid, o_err;
            logic [DATA_W-1:0] o_rdata;
            // Extra output register for the two-cycle read latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_rvalid <= 1'b0;
                    o_err    <= 1'b0;
                    o_rdata  <= '0;
                end else begin
                    o_rvalid <= s2_rvalid;
                    o_err    <= s2_err;
                    o_rdata  <= s2_rdata;
                end
            end
            assign bus.rvalid = o_rvalid;
            assign bus.err    = o_err;
            assign bus.rdata  = o_rdata;
        end else begin : g_lat1
            assign bus.rvalid = s2_rvalid;
            assign bus.err    = s2_err;
            assign bus.rdata  = s2_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Bench for sp_ram_ctrl: two instances (default 256-deep/latency 1, and 200-deep/latency 2)
// share one stimulus; a behavioural model is compared every cycle, and directed reads are
// pinned with literal values. Optional macro SP_RAM_PARITY_EN enables the parity case.
module tb_sp_ram_ctrl;

    localparam int DEP [2] = '{256, 200};
    localparam int LAT [2] = '{1, 2};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr   = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [7:0]  addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        inj   = 1'b0;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    sp_ram_ctrl_if #(.DATA_W(32), .ADDR_W(8)) bus0 ();
    sp_ram_ctrl_if #(.DATA_W(32), .ADDR_W(8)) bus1 ();

    assign bus0.req = req;   assign bus1.req = req;
    assign bus0.we = we;     assign bus1.we = we;
    assign bus0.addr = addr; assign bus1.addr = addr;
    assign bus0.wdata = wdata; assign bus1.wdata = wdata;
    assign bus0.wstrb = wstrb; assign bus1.wstrb = wstrb;
`ifdef SP_RAM_PARITY_EN
    assign bus0.inj_perr = inj; assign bus1.inj_perr = inj;
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    sp_ram_ctrl dut0 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus0));
    sp_ram_ctrl #(.DEPTH(200), .READ_LAT(2)) dut1 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus1));

    logic        rdy_w [2];
    logic        rvalid_w [2];
    logic        err_w [2];
    logic [31:0] rdata_w [2];
    assign rdy_w[0] = bus0.ready;    assign rdy_w[1] = bus1.ready;
    assign rvalid_w[0] = bus0.rvalid; assign rvalid_w[1] = bus1.rvalid;
    assign err_w[0] = bus0.err;      assign err_w[1] = bus1.err;
    assign rdata_w[0] = bus0.rdata;  assign rdata_w[1] = bus1.rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m [2][256];
    logic        bad_m [2][256];
    int          init_left [2];
    logic        sv [2][4];
    logic        se [2][4];
    logic [31:0] sd [2][4];
    logic        exp_ready [2], exp_rvalid [2], exp_err [2];
    logic [31:0] exp_rdata [2];

    task automatic model_clear_mem(input int k);
        for (int a = 0; a < 256; a++) begin
            mem_m[k][a] = '0;
            bad_m[k][a] = 1'b0;
        end
    endtask

    task automatic model_reset(input int k);
        model_clear_mem(k);
        init_left[k] = DEP[k];
        for (int s = 0; s < 4; s++) begin
            sv[k][s] = 1'b0; se[k][s] = 1'b0; sd[k][s] = '0;
        end
        exp_ready[k] = 1'b0; exp_rvalid[k] = 1'b0; exp_err[k] = 1'b0; exp_rdata[k] = '0;
    endtask

    // One clock edge: emit responses due now, accept a request, advance the clear sweep.
    task automatic model_step(input int k);
        int  s, ds;
        bit  oor;
        s = edge_cnt % 4;
        exp_rvalid[k] = sv[k][s];
        exp_err[k]    = se[k][s];
        if (sv[k][s]) exp_rdata[k] = sd[k][s];
        sv[k][s] = 1'b0;
        se[k][s] = 1'b0;
        if (init_left[k] == 0 && req) begin
            oor = (int'(addr) >= DEP[k]);
            ds  = (edge_cnt + LAT[k]) % 4;
            if (we) begin
                if (!oor) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) mem_m[k][addr][8*b +: 8] = wdata[8*b +: 8];
                    if (wstrb[0]) bad_m[k][addr] = inj;
                end
                se[k][ds] = oor;
            end else begin
                sv[k][ds] = 1'b1;
                sd[k][ds] = oor ? 32'h0 : mem_m[k][addr];
                se[k][ds] = oor || (PAR_EN && bad_m[k][addr]);
            end
        end
        if (clr) begin
            init_left[k] = DEP[k];
            model_clear_mem(k);
        end else if (init_left[k] > 0) begin
            init_left[k]--;
        end
        exp_ready[k] = (init_left[k] == 0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) model_reset(k);
        end else begin
            edge_cnt++;
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ready%0d", k),  rdy_w[k],    exp_ready[k]);
            check($sformatf("rvalid%0d", k), rvalid_w[k], exp_rvalid[k]);
            check($sformatf("err%0d", k),    err_w[k],    exp_err[k]);
            check($sformatf("rdata%0d", k),  rdata_w[k],  exp_rdata[k]);
        end
    end

    // ---------------- response logger ----------------
    typedef struct {
        int          cyc;
        logic        v;
        logic        e;
        logic [31:0] d;
    } ev_t;
    ev_t log0 [$];
    ev_t log1 [$];

    always @(posedge clk) begin
        #1;
        if (rvalid_w[0] || err_w[0]) log0.push_back('{edge_cnt, rvalid_w[0], err_w[0], rdata_w[0]});
        if (rvalid_w[1] || err_w[1]) log1.push_back('{edge_cnt, rvalid_w[1], err_w[1], rdata_w[1]});
    end

    // ---------------- stimulus helpers ----------------
    task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic ij);
        req = 1'b1; we = w; addr = a; wdata = d; wstrb = s; inj = ij;
        @(negedge clk);
        req = 1'b0; we = 1'b0; inj = 1'b0;
    endtask

    task automatic check_log(input string tag, input int k, input int cyc,
                             input logic v, input logic e, input logic [31:0] d);
        ev_t q [$];
        if (k == 0) q = log0; else q = log1;
        check($sformatf("%s_n%0d", tag, k), q.size(), 1);
        if (q.size() > 0) begin
            check($sformatf("%s_cyc%0d", tag, k), q[0].cyc, cyc);
            check($sformatf("%s_v%0d", tag, k),   q[0].v, v);
            check($sformatf("%s_err%0d", tag, k), q[0].e, e);
            if (v) check($sformatf("%s_data%0d", tag, k), q[0].d, d);
        end
    endtask

    task automatic read_check(input string tag, input logic [7:0] a,
                              input logic [31:0] d0, input logic e0,
                              input logic [31:0] d1, input logic e1);
        int acc;
        log0.delete(); log1.delete();
        acc = edge_cnt + 1;
        access(1'b0, a, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        check_log(tag, 0, acc + LAT[0], 1'b1, e0, d0);
        check_log(tag, 1, acc + LAT[1], 1'b1, e1, d1);
    endtask

    // Count edges until each instance raises ready; bounded.
    task automatic count_ready(input string tag);
        int n0 = -1;
        int n1 = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n0 < 0 && rdy_w[0]) n0 = n;
            if (n1 < 0 && rdy_w[1]) n1 = n;
            if (n0 >= 0 && n1 >= 0) break;
        end
        check({tag, "_ready_edges0"}, n0, 256);
        check({tag, "_ready_edges1"}, n1, 200);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_ready("rst");

        read_check("rd_init", 8'h10, 32'h0, 1'b0, 32'h0, 1'b0);

        access(1'b1, 8'h05, 32'hDEADBEEF, 4'b1111, 1'b0);
        access(1'b1, 8'h05, 32'h11223344, 4'b0101, 1'b0);
        read_check("rd_strb", 8'h05, 32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0);

        access(1'b1, 8'h05, 32'hFFFFFFFF, 4'b0000, 1'b0);
        read_check("rd_nostrb", 8'h05, 32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0);

        // Back-to-back reads
        access(1'b1, 8'h01, 32'h11111111, 4'hF, 1'b0);
        access(1'b1, 8'h02, 32'h22222222, 4'hF, 1'b0);
        access(1'b1, 8'h03, 32'h33333333, 4'hF, 1'b0);
        log0.delete(); log1.delete();
        acc = edge_cnt + 1;
        access(1'b0, 8'h01, '0, '0, 1'b0);
        access(1'b0, 8'h02, '0, '0, 1'b0);
        access(1'b0, 8'h03, '0, '0, 1'b0);
        repeat (4) @(negedge clk);
        check("b2b_n0", log0.size(), 3);
        check("b2b_n1", log1.size(), 3);
        for (int j = 0; j < 3; j++) begin
            if (j < log0.size()) begin
                check("b2b_cyc0", log0[j].cyc, acc + j + 1);
                check("b2b_data0", log0[j].d, 32'h11111111 * (j + 1));
            end
            if (j < log1.size()) begin
                check("b2b_cyc1", log1[j].cyc, acc + j + 2);
                check("b2b_data1", log1[j].d, 32'h11111111 * (j + 1));
            end
        end

        // 0xC8 is in range for the 256-deep instance, out of range for the 200-deep one
        log0.delete(); log1.delete();
        acc = edge_cnt + 1;
        access(1'b1, 8'hC8, 32'hCAFEF00D, 4'hF, 1'b0);
        repeat (3) @(negedge clk);
        check("wr_c8_n0", log0.size(), 0);
        check_log("wr_c8", 1, acc + 2, 1'b0, 1'b1, '0);
        read_check("rd_c8", 8'hC8, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1);

        access(1'b1, 8'hC7, 32'h12345678, 4'hF, 1'b0);
        read_check("rd_c7", 8'hC7, 32'h12345678, 1'b0, 32'h12345678, 1'b0);

        // Clear with a read accepted on the same edge
        access(1'b1, 8'h07, 32'hA5A5A5A5, 4'hF, 1'b0);
        log0.delete(); log1.delete();
        acc = edge_cnt + 1;
        clr = 1'b1;
        access(1'b0, 8'h07, '0, '0, 1'b0);
        clr = 1'b0;
        count_ready("clr");
        check_log("rd_on_clr", 0, acc + 1, 1'b1, 1'b0, 32'hA5A5A5A5);
        check_log("rd_on_clr", 1, acc + 2, 1'b1, 1'b0, 32'hA5A5A5A5);
        read_check("rd_after_clr", 8'h07, 32'h0, 1'b0, 32'h0, 1'b0);

        // clr during the sweep restarts it
        pulse_clr();
        repeat (50) @(negedge clk);
        pulse_clr();
        count_ready("clr_init");

        // Reset aborts an in-flight read
        access(1'b1, 8'h07, 32'h5A5A5A5A, 4'hF, 1'b0);
        log0.delete(); log1.delete();
        access(1'b0, 8'h07, '0, '0, 1'b0);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_abort_n0", log0.size(), 0);
        check("rst_abort_n1", log1.size(), 0);
        count_ready("rst2");
        read_check("rd_after_rst", 8'h07, 32'h0, 1'b0, 32'h0, 1'b0);

`ifdef SP_RAM_PARITY_EN
        access(1'b1, 8'h20, 32'h000000FF, 4'hF, 1'b1);
        read_check("par_inj", 8'h20, 32'h000000FF, 1'b1, 32'h000000FF, 1'b1);
        access(1'b1, 8'h20, 32'h000000FF, 4'hF, 1'b0);
        read_check("par_ok", 8'h20, 32'h000000FF, 1'b0, 32'h000000FF, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
